// File: rtl/sensor_pulse_emitter_pkg.sv
// Shared types for the four-channel pulse-train emitter.
// Holds the channel state enum, command bundle and command normaliser.
package sensor_pulse_emitter_pkg;

    localparam int CMD_CNT_W   = 16;
    localparam int CMD_NUM_W   = 8;
    localparam int DEF_MIN_GAP = 3;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HIGH,
        ST_LOW,
        ST_GUARD
    } ch_state_t;

    typedef struct packed {
        logic [CMD_CNT_W-1:0] high;
        logic [CMD_CNT_W-1:0] low;
        logic [CMD_NUM_W-1:0] num;
    } cmd_t;

    // Zero high length becomes one cycle; low is stretched to the guard gap.
    function automatic cmd_t norm_cmd(
        input logic [CMD_CNT_W-1:0] high,
        input logic [CMD_CNT_W-1:0] low,
        input logic [CMD_NUM_W-1:0] num,
        input logic [CMD_CNT_W-1:0] min_gap
    );
        cmd_t c;
        c.high = (high == '0) ? CMD_CNT_W'(1) : high;
        c.low  = (low < min_gap) ? min_gap : low;
        c.num  = num;
        return c;
    endfunction

endpackage

// File: rtl/sensor_pulse_emitter_channel.sv
// One emitter channel: FSM, phase counters and registered pulse output.
// PULSE_INVERT_EN selects an active-low output level.
module sensor_pulse_emitter_channel
    import sensor_pulse_emitter_pkg::*;
#(
    parameter int MIN_GAP = DEF_MIN_GAP
) (
    input  logic clock,
    input  logic reset_n,
    input  logic accept,
    input  logic abort,
    input  cmd_t cmd,
    output logic pulse,
    output logic busy,
    output logic done
);

`ifdef PULSE_INVERT_EN
    localparam logic ACT_LVL  = 1'b0;
`else
    localparam logic ACT_LVL  = 1'b1;
`endif
    localparam logic IDLE_LVL = ~ACT_LVL;

    localparam logic [CMD_CNT_W-1:0] GAP_LD = CMD_CNT_W'(MIN_GAP - 1);

    ch_state_t            state;
    logic [CMD_CNT_W-1:0] cnt;
    logic [CMD_CNT_W-1:0] hi_len;
    logic [CMD_CNT_W-1:0] lo_len;
    logic [CMD_NUM_W-1:0] rem;

    assign busy = (state != ST_IDLE);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            hi_len <= '0;
            lo_len <= '0;
            rem    <= '0;
            pulse  <= IDLE_LVL;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (accept) begin
                        state  <= ST_HIGH;
                        cnt    <= cmd.high - 1'b1;
                        hi_len <= cmd.high;
                        lo_len <= cmd.low;
                        rem    <= cmd.num;
                        pulse  <= ACT_LVL;
                    end
                end
                ST_HIGH: begin
                    if (abort || (cnt == '0 && rem == CMD_NUM_W'(1))) begin
                        state <= ST_GUARD;
                        cnt   <= GAP_LD;
                        pulse <= IDLE_LVL;
                    end else if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        state <= ST_LOW;
                        cnt   <= lo_len - 1'b1;
                        pulse <= IDLE_LVL;
                    end
                end
                ST_LOW: begin
                    if (abort) begin
                        state <= ST_GUARD;
                        cnt   <= GAP_LD;
                    end else if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        // rem stays 0 for continuous trains
                        state <= ST_HIGH;
                        cnt   <= hi_len - 1'b1;
                        pulse <= ACT_LVL;
                        if (rem != '0) rem <= rem - 1'b1;
                    end
                end
                ST_GUARD: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        state <= ST_IDLE;
                        done  <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/sensor_pulse_emitter.sv
// Four-channel programmable pulse-train emitter with guaranteed low gaps.
// Build with PULSE_INVERT_EN for active-low pulse outputs.
module sensor_pulse_emitter
    import sensor_pulse_emitter_pkg::*;
#(
    parameter int NUM_CH  = 4,
    parameter int CNT_W   = CMD_CNT_W,
    parameter int NUM_W   = CMD_NUM_W,
    parameter int MIN_GAP = DEF_MIN_GAP
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_channel,
    input  logic [CNT_W-1:0]  cmd_high,
    input  logic [CNT_W-1:0]  cmd_low,
    input  logic [NUM_W-1:0]  cmd_num,
    input  logic [NUM_CH-1:0] abort,
    output logic [NUM_CH-1:0] pulses,
    output logic [NUM_CH-1:0] busy,
    output logic [NUM_CH-1:0] done
);

    cmd_t              cmd_n;
    logic [NUM_CH-1:0] accept;

    assign cmd_ready = ~busy[cmd_channel];
    assign cmd_n     = norm_cmd(cmd_high, cmd_low, cmd_num,
                                CMD_CNT_W'(MIN_GAP));

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        assign accept[i] = cmd_valid && cmd_ready &&
                           (cmd_channel == 2'(i));

        sensor_pulse_emitter_channel #(
            .MIN_GAP (MIN_GAP)
        ) u_ch (
            .clock   (clock),
            .reset_n (reset_n),
            .accept  (accept[i]),
            .abort   (abort[i]),
            .cmd     (cmd_n),
            .pulse   (pulses[i]),
            .busy    (busy[i]),
            .done    (done[i])
        );
    end

endmodule

// File: tb/tb_sensor_pulse_emitter.sv
// Directed bench for sensor_pulse_emitter: vector table plus corner sequences.
// Works with or without PULSE_INVERT_EN.
module tb_sensor_pulse_emitter;

`ifdef PULSE_INVERT_EN
    localparam logic ACT = 1'b0;
`else
    localparam logic ACT = 1'b1;
`endif
    localparam logic       INACT    = ~ACT;
    localparam logic [3:0] IDLE_ALL = {4{INACT}};

    logic        clock = 1'b0;
    logic        reset_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_channel;
    logic [15:0] cmd_high;
    logic [15:0] cmd_low;
    logic [7:0]  cmd_num;
    logic [3:0]  abort;
    logic [3:0]  pulses;
    logic [3:0]  busy;
    logic [3:0]  done;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clock = ~clock;

    sensor_pulse_emitter dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_channel (cmd_channel),
        .cmd_high    (cmd_high),
        .cmd_low     (cmd_low),
        .cmd_num     (cmd_num),
        .abort       (abort),
        .pulses      (pulses),
        .busy        (busy),
        .done        (done)
    );

    typedef struct {
        int ch;
        int high;
        int low;
        int num;
        int abort_at;
        int exp_busy;
        int exp_high;
        int exp_rises;
    } vec_t;

    vec_t vt[10];

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_cmd(input int ch, input int h, input int l,
                           input int n);
        logic [31:0] hv, lv, nv, cv;
        hv = h; lv = l; nv = n; cv = ch;
        cmd_channel = cv[1:0];
        cmd_high    = hv[15:0];
        cmd_low     = lv[15:0];
        cmd_num     = nv[7:0];
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int   busy_c, high_c, rises, quiet_bad, k;
        logic prev, p;
        busy_c = 0; high_c = 0; rises = 0; quiet_bad = 0; k = 0;
        prev = INACT;
        set_cmd(v.ch, v.high, v.low, v.num);
        cmd_valid = 1'b1;
        #1;
        check($sformatf("v%0d ready", idx), int'(cmd_ready), 1);
        tick();
        cmd_valid = 1'b0;
        cmd_high  = 16'hffff;
        cmd_low   = 16'hffff;
        cmd_num   = 8'hff;
        while (busy[v.ch] && k < 2000) begin
            k++;
            p = pulses[v.ch];
            if (p == ACT) high_c++;
            if (p == ACT && prev != ACT) rises++;
            prev = p;
            busy_c++;
            if (done[v.ch]) quiet_bad++;
            for (int j = 0; j < 4; j++)
                if (j != v.ch && (pulses[j] != INACT || busy[j]))
                    quiet_bad++;
            abort = '0;
            if (k == v.abort_at) abort[v.ch] = 1'b1;
            tick();
        end
        abort = '0;
        if (k >= 2000) check($sformatf("v%0d timeout", idx), 1, 0);
        check($sformatf("v%0d busy cycles", idx), busy_c, v.exp_busy);
        check($sformatf("v%0d high cycles", idx), high_c, v.exp_high);
        check($sformatf("v%0d rises", idx), rises, v.exp_rises);
        check($sformatf("v%0d quiet", idx), quiet_bad, 0);
        check($sformatf("v%0d done", idx), int'(done[v.ch]), 1);
        check($sformatf("v%0d idle out", idx), int'(pulses[v.ch]),
              int'(INACT));
        tick();
        check($sformatf("v%0d done off", idx), int'(done[v.ch]), 0);
    endtask

    int bc[4];

    task automatic count_busy();
        for (int j = 0; j < 4; j++) if (busy[j]) bc[j]++;
    endtask

    initial begin
        int k, seen;
        //  ch high  low num abort busy high rises
        vt[0] = '{0,   4,   5,  1, -1,   7,   4, 1};
        vt[1] = '{1,   2,   0,  3, -1,  15,   6, 3};
        vt[2] = '{2,   0,   4,  2, -1,   9,   2, 2};
        vt[3] = '{3,   3,   3,  0,  2,   5,   2, 1};
        vt[4] = '{0,   1,   1,  4, -1,  16,   4, 4};
        vt[5] = '{1,   5,   6,  2, -1,  19,  10, 2};
        vt[6] = '{2,   3,   4,  0,  9,  12,   5, 2};
        vt[7] = '{3,   2,   5,  0,  4,   7,   2, 1};
        vt[8] = '{0,   2,   3,  1,  3,   5,   2, 1};
        vt[9] = '{1, 300,   0,  1, -1, 303, 300, 1};

        reset_n   = 1'b0;
        cmd_valid = 1'b0;
        abort     = '0;
        set_cmd(0, 0, 0, 0);
        #3;
        check("reset pulses", int'(pulses), int'(IDLE_ALL));
        check("reset busy", int'(busy), 0);
        check("reset done", int'(done), 0);
        tick();
        @(negedge clock);
        reset_n = 1'b1;
        tick();
        check("post reset ready", int'(cmd_ready), 1);

        for (int i = 0; i < 10; i++) run_vec(i, vt[i]);

        // ready gating, switching channel, abort racing accept
        bc = '{0, 0, 0, 0};
        set_cmd(0, 10, 3, 1);
        cmd_valid = 1'b1;
        tick();
        count_busy();
        set_cmd(0, 1, 3, 1);
        #1;
        check("busy ch0 ready", int'(cmd_ready), 0);
        tick();
        count_busy();
        check("ch0 still high", int'(pulses[0]), int'(ACT));
        set_cmd(1, 2, 3, 1);
        #1;
        check("ch1 ready", int'(cmd_ready), 1);
        tick();
        count_busy();
        check("ch1 started", int'(pulses[1]), int'(ACT));
        set_cmd(2, 1, 3, 2);
        abort = 4'b0100;
        #1;
        check("ch2 ready", int'(cmd_ready), 1);
        tick();
        count_busy();
        cmd_valid = 1'b0;
        abort     = '0;
        check("abort+accept start", int'({busy[2], pulses[2]}),
              int'({1'b1, ACT}));
        k = 0;
        while (busy != '0 && k < 200) begin
            tick();
            count_busy();
            k++;
        end
        check("multi timeout", int'(k >= 200), 0);
        check("ch0 busy len", bc[0], 13);
        check("ch1 busy len", bc[1], 5);
        check("ch2 busy len", bc[2], 8);
        tick();

        // asynchronous reset in the middle of a continuous train
        set_cmd(3, 20, 3, 0);
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        tick();
        tick();
        check("pre-reset high", int'(pulses[3]), int'(ACT));
        #2;
        reset_n = 1'b0;
        #1;
        check("async rst pulses", int'(pulses), int'(IDLE_ALL));
        check("async rst busy", int'(busy), 0);
        check("async rst done", int'(done), 0);
        #1;
        reset_n = 1'b1;
        tick();
        check("rst no done", int'(done), 0);
        tick();
        check("rst stays idle", int'(busy), 0);
        set_cmd(3, 1, 3, 1);
        cmd_valid = 1'b1;
        #1;
        check("after rst ready", int'(cmd_ready), 1);
        tick();
        cmd_valid = 1'b0;
        check("after rst start", int'({busy[3], pulses[3]}),
              int'({1'b1, ACT}));
        k = 0;
        seen = 0;
        while (k < 20) begin
            tick();
            if (done[3]) seen++;
            k++;
        end
        check("after rst done once", seen, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
